// File: rtl/sb_rx_packet_deframer.sv
// Sideband RX packet deframer: rebuilds header(+data) messages from 64-bit phases,
// checks control/data parity and drops partial messages on timeout. Optional: SB_RX_PARITY_DROP_EN.
module sb_rx_packet_deframer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_phase,
    input  logic        i_phase_valid,
    output logic [61:0] o_header,
    output logic [63:0] o_data,
    output logic        o_has_data,
    output logic        o_msg_valid,
    output logic        o_cp_err,
    output logic        o_dp_err,
    output logic        o_timeout_err
);

    localparam int unsigned HDR_W = 62;
    localparam int unsigned PH_W  = 64;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic               cp_rx_q, cp_rx_d;
    logic               dp_rx_q, dp_rx_d;

    logic [HDR_W-1:0]   header_q, header_d;
    logic [PH_W-1:0]    data_q, data_d;
    logic               has_data_q, has_data_d;
    logic               msg_valid_q, msg_valid_d;
    logic               cp_err_q, cp_err_d;
    logic               dp_err_q, dp_err_d;
    logic               timeout_q, timeout_d;

    logic               dlv_c;
    logic [HDR_W-1:0]   dlv_hdr_c;
    logic [PH_W-1:0]    dlv_data_c;
    logic               dlv_has_data_c;
    logic               dlv_cp_rx_c;
    logic               dlv_dp_rx_c;

    // Opcodes that are followed by a data phase
    function automatic logic is_data_op(input logic [4:0] op);
        return (op == 5'b00001) || (op == 5'b00101) || (op == 5'b11001) || (op == 5'b11011);
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hdr_d          = hdr_q;
        cp_rx_d        = cp_rx_q;
        dp_rx_d        = dp_rx_q;
        header_d       = header_q;
        data_d         = data_q;
        has_data_d     = has_data_q;
        msg_valid_d    = 1'b0;
        timeout_d      = 1'b0;
`ifdef SB_RX_PARITY_DROP_EN
        cp_err_d       = 1'b0;
        dp_err_d       = 1'b0;
`else
        cp_err_d       = cp_err_q;
        dp_err_d       = dp_err_q;
`endif
        dlv_c          = 1'b0;
        dlv_hdr_c      = '0;
        dlv_data_c     = '0;
        dlv_has_data_c = 1'b0;
        dlv_cp_rx_c    = 1'b0;
        dlv_dp_rx_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_phase_valid) begin
                    hdr_d   = i_phase[HDR_W-1:0];
                    cp_rx_d = i_phase[62];
                    dp_rx_d = i_phase[63];
                    if (is_data_op(i_phase[4:0])) begin
                        state_d = ST_WAIT_DATA;
                        cnt_d   = '0;
                    end else begin
                        dlv_c       = 1'b1;
                        dlv_hdr_c   = i_phase[HDR_W-1:0];
                        dlv_cp_rx_c = i_phase[62];
                        dlv_dp_rx_c = i_phase[63];
                    end
                end
            end
            ST_WAIT_DATA: begin
                // A strobe wins over timeout expiry in the same cycle
                if (i_phase_valid) begin
                    dlv_c          = 1'b1;
                    dlv_hdr_c      = hdr_q;
                    dlv_data_c     = i_phase;
                    dlv_has_data_c = 1'b1;
                    dlv_cp_rx_c    = cp_rx_q;
                    dlv_dp_rx_c    = dp_rx_q;
                    state_d        = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (dlv_c) begin
            header_d   = dlv_hdr_c;
            data_d     = dlv_data_c;
            has_data_d = dlv_has_data_c;
            cp_err_d   = (^dlv_hdr_c) != dlv_cp_rx_c;
            // Header-only messages are sent with dp=0, so any set dp is an error
            dp_err_d   = dlv_has_data_c ? ((^dlv_data_c) != dlv_dp_rx_c) : dlv_dp_rx_c;
`ifdef SB_RX_PARITY_DROP_EN
            msg_valid_d = !(cp_err_d || dp_err_d);
`else
            msg_valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            cp_rx_q     <= 1'b0;
            dp_rx_q     <= 1'b0;
            header_q    <= '0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            msg_valid_q <= 1'b0;
            cp_err_q    <= 1'b0;
            dp_err_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            cp_rx_q     <= cp_rx_d;
            dp_rx_q     <= dp_rx_d;
            header_q    <= header_d;
            data_q      <= data_d;
            has_data_q  <= has_data_d;
            msg_valid_q <= msg_valid_d;
            cp_err_q    <= cp_err_d;
            dp_err_q    <= dp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_header      = header_q;
    assign o_data        = data_q;
    assign o_has_data    = has_data_q;
    assign o_msg_valid   = msg_valid_q;
    assign o_cp_err      = cp_err_q;
    assign o_dp_err      = dp_err_q;
    assign o_timeout_err = timeout_q;

endmodule

// File: tb/tb_sb_rx_packet_deframer.sv
// Scoreboard bench for sb_rx_packet_deframer: directed phases push expected messages,
// a negedge monitor pops and compares on every msg_valid / timeout_err strobe.
module tb_sb_rx_packet_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] phase;
    logic        phase_valid;
    logic [61:0] o_header;
    logic [63:0] o_data;
    logic        o_has_data, o_msg_valid, o_cp_err, o_dp_err, o_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;

    typedef struct {
        logic        is_to;
        logic [61:0] hdr;
        logic [63:0] data;
        logic        has;
        logic        cp;
        logic        dp;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t e;

    sb_rx_packet_deframer #(.TIMEOUT_CYCLES(64)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_phase       (phase),
        .i_phase_valid (phase_valid),
        .o_header      (o_header),
        .o_data        (o_data),
        .o_has_data    (o_has_data),
        .o_msg_valid   (o_msg_valid),
        .o_cp_err      (o_cp_err),
        .o_dp_err      (o_dp_err),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ph(input logic [63:0] p);
        @(negedge clk);
        phase       = p;
        phase_valid = 1'b1;
        last_cyc    = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            phase_valid = 1'b0;
            phase       = '0;
        end
    endtask

    task automatic exp_msg(input logic [61:0] h, input logic [63:0] d, input logic hd,
                           input logic cp, input logic dp);
        exp_t x;
        x.is_to = 1'b0; x.hdr = h; x.data = d; x.has = hd; x.cp = cp; x.dp = dp;
        x.at = last_cyc + 1;
        q.push_back(x);
    endtask

    task automatic exp_timeout();
        exp_t x;
        x.is_to = 1'b1; x.hdr = '0; x.data = '0; x.has = 1'b0; x.cp = 1'b0; x.dp = 1'b0;
        x.at = last_cyc + 65;
        q.push_back(x);
    endtask

    // Monitor: every output strobe must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (o_msg_valid || o_timeout_err)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {62'd0, o_msg_valid, o_timeout_err}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(e.at));
                chk("timeout_err", 64'(o_timeout_err), 64'(e.is_to));
                chk("msg_valid", 64'(o_msg_valid), 64'(!e.is_to));
                if (!e.is_to) begin
                    chk("header", 64'(o_header), 64'(e.hdr));
                    chk("data", o_data, e.data);
                    chk("has_data", 64'(o_has_data), 64'(e.has));
                    chk("cp_err", 64'(o_cp_err), 64'(e.cp));
                    chk("dp_err", 64'(o_dp_err), 64'(e.dp));
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        phase       = '0;
        phase_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_header", 64'(o_header), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_flags", {59'd0, o_has_data, o_msg_valid, o_cp_err, o_dp_err, o_timeout_err}, 64'd0);

        // Header-only message
        ph(64'h0000_0000_0000_0012); exp_msg(62'h12, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Header + data with a gap
        ph(64'h8000_0000_0000_001B); idle(2);
        ph(64'h1); exp_msg(62'h1B, 64'h1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Parity errors
        ph(64'h4000_0000_0000_0012);
`ifndef SB_RX_PARITY_DROP_EN
        exp_msg(62'h12, 64'h0, 1'b0, 1'b1, 1'b0);
`endif
        idle(1);
        ph(64'h0000_0000_0000_001B); ph(64'h1);
`ifndef SB_RX_PARITY_DROP_EN
        exp_msg(62'h1B, 64'h1, 1'b1, 1'b0, 1'b1);
`endif
        idle(1);

        // Timeout after 64 idle cycles, then a header-only message
        ph(64'h8000_0000_0000_001B); exp_timeout();
        idle(64);
        ph(64'h0000_0000_0000_0012); exp_msg(62'h12, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Data strobe on the last allowed cycle is accepted
        ph(64'h8000_0000_0000_001B); idle(63);
        ph(64'h0000_0000_0000_0003); exp_msg(62'h1B, 64'h3, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Reset while waiting for data discards the header
        ph(64'h8000_0000_0000_001B); idle(2);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_header", 64'(o_header), 64'd0);
        chk("midrst_flags", {62'd0, o_has_data, o_dp_err}, 64'd0);
        ph(64'h0000_0000_0000_0012); exp_msg(62'h12, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(80);

        // Back-to-back strobes
        ph(64'h0000_0000_0000_0012); exp_msg(62'h12, 64'h0, 1'b0, 1'b0, 1'b0);
        ph(64'h8000_0000_0000_001B);
        ph(64'h1); exp_msg(62'h1B, 64'h1, 1'b1, 1'b0, 1'b0);
        ph(64'h0000_0000_0000_0012); exp_msg(62'h12, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("hold_header", 64'(o_header), 64'h12);

        idle(100);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
